// File: rtl/la_clkgate_ctrl.sv
// Clock-gating enable controller: produces the registered enable for the ICG latch/AND stage.
// Optional gated-cycle statistics counter enabled by defining LA_CLKGATE_STATS_EN.
module la_clkgate_ctrl #(
  parameter string PROP = "DEFAULT",
  parameter int    CW   = 8,
  parameter int    WAKE = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          busy,
  input  logic          req,
  input  logic [CW-1:0] idle_cycles,
  input  logic          testen,
  input  logic          stats_clr,
  output logic          en,
  output logic          ack,
  output logic          gated,
  output logic [31:0]   gated_count
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_IDLE  = 2'd1,
    S_GATED = 2'd2,
    S_WAKE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] icnt, icnt_nxt;
  logic [CW-1:0] wcnt, wcnt_nxt;
  logic          en_q;
  logic          ack_nxt;
  logic          act;

  // Any activity (local or neighbour request) keeps or brings the clock back.
  assign act = busy | req;

  always_comb begin
    state_nxt = state;
    icnt_nxt  = icnt;
    wcnt_nxt  = wcnt;
    case (state)
      S_RUN: begin
        // A held req/ack handshake implies req=1, so act already pins RUN.
        if (!act && (idle_cycles != '0)) begin
          state_nxt = S_IDLE;
          icnt_nxt  = idle_cycles;
        end
      end
      S_IDLE: begin
        if (act) begin
          state_nxt = S_RUN;
        end else if (icnt == CW'(1)) begin
          state_nxt = S_GATED;
        end else begin
          icnt_nxt = icnt - CW'(1);
        end
      end
      S_GATED: begin
        if (act) begin
          if (WAKE != 0) begin
            state_nxt = S_WAKE;
            wcnt_nxt  = CW'(WAKE);
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_WAKE: begin
        // Wake runs to completion even if busy/req drop meanwhile.
        if (wcnt <= CW'(1)) begin
          state_nxt = S_RUN;
        end else begin
          wcnt_nxt = wcnt - CW'(1);
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // ack only rises when landing in RUN with req still up; drops as soon as req does.
  assign ack_nxt = req & (ack | (state_nxt == S_RUN));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= S_RUN;
      icnt  <= '0;
      wcnt  <= '0;
      en_q  <= 1'b1;
      gated <= 1'b0;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      icnt  <= icnt_nxt;
      wcnt  <= wcnt_nxt;
      en_q  <= (state_nxt != S_GATED);
      gated <= (state_nxt == S_GATED);
      ack   <= ack_nxt;
    end
  end

  assign en = en_q | testen;

`ifdef LA_CLKGATE_STATS_EN
  logic [31:0] gcnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      gcnt <= '0;
    end else if (stats_clr) begin
      gcnt <= '0;
    end else if ((state == S_GATED) && (gcnt != 32'hFFFF_FFFF)) begin
      gcnt <= gcnt + 32'd1;
    end
  end

  assign gated_count = gcnt;
`else
  assign gated_count = '0;
`endif

  // PROP is a pass-through tag; stats_clr is only consumed by the stats build.
  logic unused;
  assign unused = ^{stats_clr, (PROP != "")};

endmodule

// File: tb/tb_la_clkgate_ctrl.sv
// Directed self-checking bench for la_clkgate_ctrl (CW=8, WAKE=2).
module tb_la_clkgate_ctrl;

  logic        clk = 1'b0;
  logic        nreset;
  logic        busy, req, testen, stats_clr;
  logic [7:0]  idle_cycles;
  logic        en, ack, gated;
  logic [31:0] gated_count;

  int vecs = 0;
  int errs = 0;

`ifdef LA_CLKGATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  la_clkgate_ctrl #(.PROP("DEFAULT"), .CW(8), .WAKE(2)) dut (
    .clk(clk), .nreset(nreset), .busy(busy), .req(req),
    .idle_cycles(idle_cycles), .testen(testen), .stats_clr(stats_clr),
    .en(en), .ack(ack), .gated(gated), .gated_count(gated_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0; busy = 1'b0; req = 1'b0; testen = 1'b0; stats_clr = 1'b0;
    idle_cycles = 8'd4;
    #12;
    vecs++; if (en !== 1'b1) begin errs++; $display("FAIL reset_en got %b exp 1", en); end
    vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL reset_ack got %b exp 0", ack); end
    vecs++; if (gated !== 1'b0) begin errs++; $display("FAIL reset_gated got %b exp 0", gated); end
    vecs++; if (gated_count !== 32'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", gated_count); end
  endtask

  task automatic test_idle_gate();
    nreset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vecs++; if (en !== 1'b1) begin errs++; $display("FAIL idle_en_hold[%0d] got %b exp 1", k, en); end
    end
    tick();
    vecs++; if (en !== 1'b0) begin errs++; $display("FAIL idle_en_drop got %b exp 0", en); end
    vecs++; if (gated !== 1'b1) begin errs++; $display("FAIL idle_gated got %b exp 1", gated); end
  endtask

  task automatic test_wake();
    req = 1'b1;
    tick();
    vecs++; if (en !== 1'b1) begin errs++; $display("FAIL wake_en got %b exp 1", en); end
    vecs++; if (gated !== 1'b0) begin errs++; $display("FAIL wake_gated got %b exp 0", gated); end
    vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL wake_ack_e0 got %b exp 0", ack); end
    tick();
    vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL wake_ack_e1 got %b exp 0", ack); end
    tick();
    vecs++; if (ack !== 1'b1) begin errs++; $display("FAIL wake_ack_e2 got %b exp 1", ack); end
    req = 1'b0;
    tick();
    vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL wake_ack_clr got %b exp 0", ack); end
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++; if (en !== 1'b1) begin errs++; $display("FAIL wake_reidle_en[%0d] got %b exp 1", k, en); end
    end
    tick();
    vecs++; if (en !== 1'b0) begin errs++; $display("FAIL wake_regate_en got %b exp 0", en); end
  endtask

  task automatic test_wake_abort();
    req = 1'b1;
    tick();
    vecs++; if (en !== 1'b1) begin errs++; $display("FAIL abort_en got %b exp 1", en); end
    req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL abort_ack[%0d] got %b exp 0", k, ack); end
    end
  endtask

  task automatic test_no_gate();
    idle_cycles = 8'd0;
    for (int k = 0; k < 100; k++) begin
      tick();
      vecs++;
      if (en !== 1'b1 || gated !== 1'b0) begin
        errs++; $display("FAIL nogate[%0d] got en=%b gated=%b exp en=1 gated=0", k, en, gated);
      end
    end
  endtask

  task automatic test_busy_at_expiry();
    idle_cycles = 8'd4;
    for (int k = 0; k < 4; k++) begin
      tick();
      vecs++; if (en !== 1'b1) begin errs++; $display("FAIL expiry_pre[%0d] got %b exp 1", k, en); end
    end
    busy = 1'b1;
    tick();
    vecs++;
    if (en !== 1'b1 || gated !== 1'b0) begin
      errs++; $display("FAIL expiry_race got en=%b gated=%b exp en=1 gated=0", en, gated);
    end
    busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      vecs++; if (en !== 1'b1) begin errs++; $display("FAIL expiry_reload[%0d] got %b exp 1", k, en); end
    end
    tick();
    vecs++; if (en !== 1'b0) begin errs++; $display("FAIL expiry_regate got %b exp 0", en); end
  endtask

  task automatic test_testen_reset();
    testen = 1'b1;
    #1;
    vecs++; if (en !== 1'b1) begin errs++; $display("FAIL testen_en got %b exp 1", en); end
    vecs++; if (gated !== 1'b1) begin errs++; $display("FAIL testen_gated got %b exp 1", gated); end
    tick();
    vecs++; if (gated !== 1'b1) begin errs++; $display("FAIL testen_hold got %b exp 1", gated); end
    testen = 1'b0;
    #1;
    vecs++; if (en !== 1'b0) begin errs++; $display("FAIL testen_off got %b exp 0", en); end
    busy = 1'b1;
    tick();
    busy = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    vecs++; if (en !== 1'b1) begin errs++; $display("FAIL rst_wake_en got %b exp 1", en); end
    vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL rst_wake_ack got %b exp 0", ack); end
    vecs++; if (gated !== 1'b0) begin errs++; $display("FAIL rst_wake_gated got %b exp 0", gated); end
    nreset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vecs++; if (en !== 1'b1) begin errs++; $display("FAIL rst_idle[%0d] got %b exp 1", k, en); end
    end
    tick();
    vecs++; if (en !== 1'b0) begin errs++; $display("FAIL rst_regate got %b exp 0", en); end
  endtask

  task automatic test_stats();
    logic [31:0] exp;
    stats_clr = 1'b1;
    tick();
    vecs++; if (gated_count !== 32'd0) begin errs++; $display("FAIL stats_clr0 got %0d exp 0", gated_count); end
    stats_clr = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    exp = STATS ? 32'd10 : 32'd0;
    vecs++; if (gated_count !== exp) begin errs++; $display("FAIL stats_10 got %0d exp %0d", gated_count, exp); end
    vecs++; if (gated !== 1'b1) begin errs++; $display("FAIL stats_gated got %b exp 1", gated); end
    stats_clr = 1'b1;
    tick();
    vecs++; if (gated_count !== 32'd0) begin errs++; $display("FAIL stats_clr_prio got %0d exp 0", gated_count); end
    stats_clr = 1'b0;
    tick();
    exp = STATS ? 32'd1 : 32'd0;
    vecs++; if (gated_count !== exp) begin errs++; $display("FAIL stats_restart got %0d exp %0d", gated_count, exp); end
  endtask

  initial begin
    test_reset();
    test_idle_gate();
    test_wake();
    test_wake_abort();
    test_no_gate();
    test_busy_at_expiry();
    test_testen_reset();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
